// File: rtl/vram_sam.sv
// Dual-port video DRAM model: random-access port plus a serial access memory (SAM)
// fed by full or split read transfers. All DRAM strobes are edge-detected on MCLK.
module vram_sam #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic          MCLK,
  input  logic          RESET,
  input  logic          RAS,
  input  logic          CAS,
  input  logic          WE,
  input  logic          OE,
  input  logic          DSF,
  input  logic          SC,
  input  logic          SE,
  input  logic [AW-1:0] AD,
  input  logic [DW-1:0] RD_i,
  output logic [DW-1:0] RD_o,
  output logic          RD_d,
  output logic [DW-1:0] SD_o,
  output logic          SD_d,
  output logic          QSF
);

  logic [DW-1:0] mem [0:(2**(2*AW))-1];

  logic          ras_p1, oe_p1, sc_p1, cas_p1, armed;
  logic [AW-1:0] row, col, page, ptr, pend_page, pend_start;
  logic [DW-1:0] mask, ser;
  logic          dt, split, pend_v, valid, valid_d, qsf_p1;
  logic          cas, ras_fall, cas_rise, oe_rise, sc_rise, xfer, wr_en;

  function automatic logic [DW-1:0] merge_bits(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [DW-1:0] bit_en);
    return (old_w & ~bit_en) | (new_w & bit_en);
  endfunction

  assign cas = ~RAS & ~CAS;
  // armed stays low for the first edge after reset so strobes held active across release never fire
  assign ras_fall = armed & ras_p1 & ~RAS;
  assign cas_rise = armed & ~cas_p1 & cas;
  assign oe_rise  = armed & ~oe_p1 & OE;
  assign sc_rise  = armed & ~sc_p1 & SC;
  assign xfer     = oe_rise & dt;
  assign wr_en    = armed & cas & ~WE & ~dt;

  assign RD_d = ~valid_d;
  assign SD_d = SE;
  assign QSF  = qsf_p1;

  // Array write: bit-granular under the mask latched at RAS fall
  always_ff @(posedge MCLK) begin
    if (wr_en)
      mem[{row, col}] <= merge_bits(mem[{row, col}], RD_i, mask);
  end

  // Strobe sampling, address latches, read path and SAM control
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      armed      <= 1'b0;
      ras_p1     <= 1'b1;
      oe_p1      <= 1'b1;
      sc_p1      <= 1'b0;
      cas_p1     <= 1'b0;
      RD_o       <= '0;
      SD_o       <= '0;
      ser        <= '0;
      row        <= '0;
      col        <= '0;
      page       <= '0;
      ptr        <= '0;
      pend_page  <= '0;
      pend_start <= '0;
      mask       <= '1;
      dt         <= 1'b0;
      split      <= 1'b0;
      pend_v     <= 1'b0;
      valid      <= 1'b0;
      valid_d    <= 1'b0;
      qsf_p1     <= 1'b0;
    end else begin
      armed   <= 1'b1;
      ras_p1  <= RAS;
      oe_p1   <= OE;
      sc_p1   <= SC;
      cas_p1  <= cas;
      RD_o    <= mem[{row, col}];
      ser     <= mem[{page, ptr}];
      qsf_p1  <= ptr[AW-1];
      valid_d <= valid;

      if (ras_fall) begin
        row   <= AD;
        dt    <= ~OE;
        split <= ~OE & DSF & SPLIT_EN;
        mask  <= (~WE & OE) ? RD_i : '1;
      end
      if (cas_rise)
        col <= AD;

      if (CAS || OE)
        valid <= 1'b0;
      else if (~RAS && ~dt)
        valid <= 1'b1;

      // A completing transfer takes priority; the coincident SC edge is discarded
      if (xfer) begin
        if (split) begin
          pend_page  <= row;
          pend_start <= {~ptr[AW-1], col[AW-2:0]};
          pend_v     <= 1'b1;
        end else begin
          page   <= row;
          ptr    <= col;
          pend_v <= 1'b0;
        end
      end else if (sc_rise) begin
        SD_o <= ser;
        if (pend_v && (&ptr[AW-2:0])) begin
          page   <= pend_page;
          ptr    <= pend_start;
          pend_v <= 1'b0;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/vram_sam.md
Name: vram_sam

Overview:
- Parametrised behavioural model of a dual-port video DRAM with a random-access port and a serial-access (SAM) port, for MD/System-18 video simulation and FPGA builds.
- Generalises the earlier 8-bit/64K model in three ways:
  - configurable data and address widths;
  - write-per-bit masking;
  - split-SAM read transfers that reload one half of the serial buffer while the other half keeps shifting, with a QSF half indicator.
- All DRAM strobes are sampled and edge-detected in the MCLK domain.

Parameters:
- DW, 8, data width of both ports.
- AW, 8, row and column address width. Memory is 2^(2*AW) words of DW bits.
- SPLIT_EN, 1, enables split transfers. When 0, DSF is ignored and every transfer is a full transfer.

Ports:
- MCLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RAS  in  1  row strobe, active low.
- CAS  in  1  column strobe, active low.
- WE  in  1  write enable, active low.
- OE  in  1  output enable / transfer strobe, active low.
- DSF  in  1  special-function select, sampled at RAS fall; 1 selects a split transfer.
- SC  in  1  serial clock; the rising edge advances the SAM.
- SE  in  1  serial enable, active low.
- AD  in  AW  multiplexed row/column address.
- RD_i  in  DW  random-port write data; also supplies the write mask at RAS fall.
- RD_o  out  DW  random-port read data.
- RD_d  out  1  random-port output disable (1 = tri-stated).
- SD_o  out  DW  serial data.
- SD_d  out  1  serial output disable; equals SE combinationally.
- QSF  out  1  MSB of the SAM pointer: which half is currently shifting.

Behaviour:
- Edge detection
  - Previous-value registers for RAS, OE, SC and cas (cas = ~RAS & ~CAS).
  - Reset values are the idle levels: RAS=1, OE=1, SC=0, cas=0. No spurious edge fires after reset release.
- RAS fall (edge cycle N)
  - row <= AD.
  - dt <= ~OE.
  - split <= dt & DSF & SPLIT_EN.
  - If WE is low and dt is 0: mask <= RD_i (masked write cycle). Otherwise mask <= all ones.
- cas rise: col <= AD.
  - If RAS and CAS fall in the same cycle, row and col are both latched from AD.
- Write
  - Applies on every MCLK edge where ~RAS & ~CAS & ~WE & ~dt.
  - Bit-granular: only bits with mask=1 take RD_i; all other bits keep their previous value.
  - The mask is cleared back to all ones only by the next RAS fall.
- Read
  - RD_o <= mem[{row,col}] every cycle: 1-cycle latency from an address change.
  - valid sets at the first edge where ~RAS & ~CAS & ~OE & ~dt, and clears when CAS or OE is high.
  - RD_d = ~valid_d, where valid_d is valid delayed one cycle.
  - Net effect: RD_d falls 2 MCLK after the CAS-fall edge, coincident with correct RD_o.
- Full read transfer (dt & ~split, OE rising edge)
  - page <= row; ptr <= col; pend_v <= 0.
- Split transfer (dt & split, OE rising edge)
  - pend_page <= row.
  - pend_start <= {~ptr[AW-1], col[AW-2:0]}, i.e. it targets the inactive half.
  - pend_v <= 1. The active page and ptr are untouched.
- SC rise (when no transfer completes that cycle)
  - SD_o <= ser, where ser = mem[{page,ptr}] registered each cycle.
  - If pend_v and ptr[AW-2:0] is all ones: page <= pend_page, ptr <= pend_start, pend_v <= 0.
  - Otherwise ptr <= ptr+1, wrapping modulo 2^AW within the page.
- Conflicts and timing
  - A transfer completing in the same cycle as an SC rise wins; that SC edge is dropped.
  - SC high and low phases must each be ≥2 MCLK.
  - After a full transfer, the first SC rise must come ≥2 MCLK after the OE rise.
- QSF = ptr[AW-1], registered.
- RESET
  - Clears RD_o, SD_o, ser, row, col, page, ptr, pend_page, pend_start, dt, split, pend_v, valid and valid_d.
  - Sets mask to all ones.
  - Outputs: RD_d=1, QSF=0.
  - Memory contents are preserved.
  - Reset asserted mid-cycle aborts any access; no write occurs while RESET is high.

Test Plan:
1. Write 0xA5 to row 0x12 / col 0x34 (WE low after RAS), then read it back → RD_o=0xA5 with RD_d=0 exactly 2 MCLK after the CAS-fall edge; RD_d=1 after CAS rises.
2. Masked write: location holds 0xFF; RAS fall with WE low and RD_i=0x0F; then write 0x00 → location reads 0xF0; the next unmasked write of 0x00 → 0x00.
3. Full transfer: row 0x20, col 0xFE; issue 4 SC pulses → SD_o = mem[20FE], mem[20FF], mem[2000], mem[2001] (wrap); QSF goes 1→1→0→0.
4. Split transfer: during shifting in the lower half, split transfer row 0x40 col 0x10; shift to col 0x7F → next SC gives mem[4090]; QSF=1; pend_v cleared.
5. RESET pulsed mid-read and mid-serial → RD_d=1, SD_o=0, QSF=0 immediately; memory still holds the prior data; no SC edge is taken on release with SC held high.
6. OE rise (transfer) and SC rise in the same cycle → ptr loads col and SD_o is unchanged.
